pattern_sequencer: RTL and testbench

- Top-level controller for the pattern generators.
- Generates the per-frame `next_frame` tick and the shared `step_size` that drive every generator's animation.
- Selects which of four generator RGB outputs reaches the display.
- Auto-cycles through patterns with a fade-out / switch / fade-in transition, and also advances on a user button.

---
 rtl/pattern_pkg.sv | 27 ++
 rtl/pattern_sequencer_if.sv | 23 ++
 rtl/pattern_sequencer_btn_edge.sv | 28 ++
 rtl/pattern_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern sequencer slice: FSM states,
// video timing constants and the per-channel brightness clamp.
package pattern_pkg;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam int          H_ACTIVE   = 640;
    localparam int          V_ACTIVE   = 480;
    localparam int          RGB_W      = 6;
    localparam logic [1:0]  LEVEL_MAX  = 2'd3;
    localparam logic [2:0]  STEP_RESET = 3'd1;

    function automatic logic [1:0] clamp2(input logic [1:0] chan, input logic [1:0] level);
        return (chan < level) ? chan : level;
    endfunction

    // Fading is a per-channel ceiling rather than a scale, so level 3 is an exact pass-through.
    function automatic logic [RGB_W-1:0] dim_rgb(input logic [RGB_W-1:0] pix, input logic [1:0] level);
        return {clamp2(pix[5:4], level), clamp2(pix[3:2], level), clamp2(pix[1:0], level)};
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Video-side bundle between the scan timing / generators and the sequencer.
interface pattern_sequencer_if;
    import pattern_pkg::*;

    logic [9:0]           x;
    logic [9:0]           y;
    logic [4*RGB_W-1:0]   pat_rgb;
    logic                 next_frame;
    logic [2:0]           step_size;
    logic [1:0]           pattern_sel;
    logic [RGB_W-1:0]     rgb;

    modport master (
        output x, y, pat_rgb,
        input  next_frame, step_size, pattern_sel, rgb
    );

    modport slave (
        input  x, y, pat_rgb,
        output next_frame, step_size, pattern_sel, rgb
    );

endinterface

// File: rtl/pattern_sequencer_btn_edge.sv
// Button conditioner: two-flop synchroniser followed by a registered rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic sync_prev;

    // The pulse lands three clocks after the raw edge; holding the button yields one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            sync_prev <= sync2;
            pulse     <= sync2 & ~sync_prev;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer top: frame tick, speed control, pattern select and fade FSM.
// Define AUTO_CYCLE_EN to enable the dwell-expiry auto-advance out of SHOW.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int DWELL_FRAMES     = 300,
    parameter int FADE_STEP_FRAMES = 4,
    parameter int NUM_PATTERNS     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_next,
    input  logic                btn_speed,
    pattern_sequencer_if.slave  vid
);

    localparam int               SUB_W    = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(FADE_STEP_FRAMES - 1);
    localparam logic [1:0]       SEL_LAST = 2'(NUM_PATTERNS - 1);

    logic             next_pulse;
    logic             speed_pulse;
    logic             frame_start;
    logic             frame_start_q;
    logic             next_frame_q;
    logic [2:0]       step_q;
    logic [1:0]       level;
    logic [1:0]       pattern_sel_q;
    logic [SUB_W-1:0] sub_cnt;
    logic [RGB_W-1:0] rgb_q;
    logic             fade_step;
    logic             dwell_expire;
    state_t           state;
    state_t           next_state;

    logic sub_en;
    logic level_dn;
    logic level_up;
    logic sel_adv;

    btn_edge u_btn_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (next_pulse)
    );

    btn_edge u_btn_speed (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_speed),
        .pulse (speed_pulse)
    );

    // Edge-detect the frame-start pixel so a stalled scan position cannot produce repeat ticks.
    assign frame_start = (vid.x == 10'd0) && (vid.y == 10'(V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start_q <= 1'b0;
            next_frame_q  <= 1'b0;
        end else begin
            frame_start_q <= frame_start;
            next_frame_q  <= frame_start & ~frame_start_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= STEP_RESET;
        end else if (speed_pulse) begin
            step_q <= (step_q == 3'd7) ? 3'd1 : step_q + 3'd1;
        end
    end

    assign fade_step = next_frame_q && (sub_cnt == SUB_LAST);

`ifdef AUTO_CYCLE_EN
    localparam int                DWELL_W    = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_en;
    logic               dwell_clr;

    assign dwell_expire = next_frame_q && (dwell_cnt == DWELL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if (dwell_clr) begin
            dwell_cnt <= '0;
        end else if (dwell_en) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end
`else
    assign dwell_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW;
        end else begin
            state <= next_state;
        end
    end

    // A button press and a dwell expiry in the same cycle still give just one FADE_OUT entry.
    always_comb begin
        next_state = state;
        case (state)
            SHOW:     if (next_pulse || dwell_expire)            next_state = FADE_OUT;
            FADE_OUT: if (fade_step && (level == 2'd1))          next_state = SWITCH;
            SWITCH:                                              next_state = FADE_IN;
            FADE_IN:  if (fade_step && (level == LEVEL_MAX - 2'd1)) next_state = SHOW;
            default:                                             next_state = SHOW;
        endcase
    end

    always_comb begin
        sub_en   = 1'b0;
        level_dn = 1'b0;
        level_up = 1'b0;
        sel_adv  = 1'b0;
`ifdef AUTO_CYCLE_EN
        dwell_en  = 1'b0;
        dwell_clr = 1'b0;
`endif
        case (state)
            SHOW: begin
`ifdef AUTO_CYCLE_EN
                dwell_en  = next_frame_q;
                dwell_clr = (next_state != SHOW);
`endif
            end
            FADE_OUT: begin
                sub_en   = next_frame_q;
                level_dn = fade_step;
            end
            SWITCH: begin
                sel_adv = 1'b1;
            end
            FADE_IN: begin
                sub_en   = next_frame_q;
                level_up = fade_step;
            end
            default: begin
                sub_en = 1'b0;
            end
        endcase
    end

    // Sub-count wraps to zero on every brightness step, so each fade phase starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt       <= '0;
            level         <= LEVEL_MAX;
            pattern_sel_q <= 2'd0;
        end else begin
            if (sub_en) begin
                sub_cnt <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + 1'b1;
            end
            if (level_dn) begin
                level <= level - 2'd1;
            end else if (level_up) begin
                level <= level + 2'd1;
            end
            if (sel_adv) begin
                pattern_sel_q <= (pattern_sel_q == SEL_LAST) ? 2'd0 : pattern_sel_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= dim_rgb(vid.pat_rgb[pattern_sel_q*RGB_W +: RGB_W], level);
        end
    end

    assign vid.next_frame  = next_frame_q;
    assign vid.step_size   = step_q;
    assign vid.pattern_sel = pattern_sel_q;
    assign vid.rgb         = rgb_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed testbench for pattern_sequencer with short synthetic frames
// (DWELL_FRAMES=5, FADE_STEP_FRAMES=2).
module tb_pattern_sequencer;
    import pattern_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic btn_next;
    logic btn_speed;

    pattern_sequencer_if vid();

    pattern_sequencer #(
        .DWELL_FRAMES     (5),
        .FADE_STEP_FRAMES (2),
        .NUM_PATTERNS     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_next  (btn_next),
        .btn_speed (btn_speed),
        .vid       (vid)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [23:0] pat;
        logic [5:0]  exp_rgb;
    } pix_vec_t;

    pix_vec_t pix_tbl[5];
    int       speed_exp[7];

    // Inputs change on the falling edge, so every check also sees settled outputs.
    task automatic applyStimulus(input logic [9:0] xv, input logic [9:0] yv,
                                 input logic [23:0] pat, input int cycles);
        vid.x       = xv;
        vid.y       = yv;
        vid.pat_rgb = pat;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic runFrames(input int n, input logic [23:0] pat);
        for (int f = 0; f < n; f++) begin
            applyStimulus(10'd0, 10'd480, pat, 1);
            applyStimulus(10'd5, 10'd10, pat, 2);
        end
    endtask

    task automatic pressNext(input int hold, input logic [23:0] pat);
        btn_next = 1'b1;
        applyStimulus(10'd5, 10'd10, pat, hold);
        btn_next = 1'b0;
        applyStimulus(10'd5, 10'd10, pat, 3);
    endtask

    logic [23:0] pat;

    initial begin
        pix_tbl[0] = '{ {18'h2AAAA, 6'b111001}, 6'b111001 };
        pix_tbl[1] = '{ {18'h3FFFF, 6'b000000}, 6'b000000 };
        pix_tbl[2] = '{ {18'h00000, 6'b101010}, 6'b101010 };
        pix_tbl[3] = '{ {18'h15555, 6'b010110}, 6'b010110 };
        pix_tbl[4] = '{ {18'h3FFFF, 6'b110011}, 6'b110011 };
        speed_exp  = '{2, 3, 4, 5, 6, 7, 1};

        rst       = 1'b1;
        btn_next  = 1'b0;
        btn_speed = 1'b0;
        vid.x       = 10'd1;
        vid.y       = 10'd0;
        vid.pat_rgb = 24'hFFFFFF;
        @(negedge clk);
        applyStimulus(10'd1, 10'd0, 24'hFFFFFF, 2);
        checkOutput("reset next_frame", {23'd0, vid.next_frame}, 24'd0);
        checkOutput("reset step_size", {21'd0, vid.step_size}, 24'd1);
        checkOutput("reset pattern_sel", {22'd0, vid.pattern_sel}, 24'd0);
        checkOutput("reset rgb", {18'd0, vid.rgb}, 24'd0);
        rst = 1'b0;

        applyStimulus(10'd0, 10'd479, 24'hFFFFFF, 1);
        checkOutput("tick y479", {23'd0, vid.next_frame}, 24'd0);
        applyStimulus(10'd1, 10'd480, 24'hFFFFFF, 1);
        checkOutput("tick x1", {23'd0, vid.next_frame}, 24'd0);
        applyStimulus(10'd0, 10'd480, 24'hFFFFFF, 1);
        checkOutput("tick pulse", {23'd0, vid.next_frame}, 24'd1);
        applyStimulus(10'd0, 10'd480, 24'hFFFFFF, 1);
        checkOutput("tick held", {23'd0, vid.next_frame}, 24'd0);
        applyStimulus(10'd5, 10'd10, 24'hFFFFFF, 1);
        checkOutput("tick after", {23'd0, vid.next_frame}, 24'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(10'd5, 10'd10, pix_tbl[i].pat, 1);
            checkOutput($sformatf("pixel vec %0d", i), {18'd0, vid.rgb}, {18'd0, pix_tbl[i].exp_rgb});
        end

`ifdef AUTO_CYCLE_EN
        rst = 1'b1;
        applyStimulus(10'd5, 10'd10, 24'hFFFFFF, 1);
        rst = 1'b0;
        runFrames(5, 24'hFFFFFF);
        checkOutput("dwell entry rgb", {18'd0, vid.rgb}, 24'h3F);
        runFrames(2, 24'hFFFFFF);
        checkOutput("dwell fade lvl2", {18'd0, vid.rgb}, 24'h2A);
        runFrames(4, 24'hFFFFFF);
        checkOutput("dwell switch sel", {22'd0, vid.pattern_sel}, 24'd1);
        checkOutput("dwell switch black", {18'd0, vid.rgb}, 24'd0);
        runFrames(6, 24'hFFFFFF);
        checkOutput("dwell show rgb", {18'd0, vid.rgb}, 24'h3F);
        rst = 1'b1;
        applyStimulus(10'd5, 10'd10, 24'hFFFFFF, 1);
        rst = 1'b0;
        applyStimulus(10'd5, 10'd10, 24'hFFFFFF, 1);
`else
        runFrames(1000, 24'hFFFFFF);
        checkOutput("no auto sel", {22'd0, vid.pattern_sel}, 24'd0);
        checkOutput("no auto rgb", {18'd0, vid.rgb}, 24'h3F);
`endif

        pat = {18'h3FFFF, 6'b111001};
        pressNext(10, pat);
        checkOutput("press no step yet", {18'd0, vid.rgb}, 24'h39);
        runFrames(2, pat);
        checkOutput("fade out lvl2", {18'd0, vid.rgb}, {18'd0, 6'b101001});
        runFrames(2, pat);
        checkOutput("fade out lvl1", {18'd0, vid.rgb}, {18'd0, 6'b010101});
        runFrames(1, pat);
        checkOutput("fade out hold", {18'd0, vid.rgb}, {18'd0, 6'b010101});
        checkOutput("sel before switch", {22'd0, vid.pattern_sel}, 24'd0);
        runFrames(1, pat);
        checkOutput("switch sel", {22'd0, vid.pattern_sel}, 24'd1);
        checkOutput("switch black", {18'd0, vid.rgb}, 24'd0);
        runFrames(2, pat);
        checkOutput("fade in lvl1", {18'd0, vid.rgb}, {18'd0, 6'b010101});
        pressNext(10, pat);
        runFrames(4, pat);
        checkOutput("fade in done", {18'd0, vid.rgb}, 24'h3F);
        checkOutput("sel single adv", {22'd0, vid.pattern_sel}, 24'd1);
        runFrames(2, pat);
        checkOutput("press not queued", {18'd0, vid.rgb}, 24'h3F);

        for (int i = 0; i < 7; i++) begin
            btn_speed = 1'b1;
            applyStimulus(10'd5, 10'd10, pat, 2);
            btn_speed = 1'b0;
            applyStimulus(10'd5, 10'd10, pat, 3);
            checkOutput($sformatf("speed press %0d", i + 1), {21'd0, vid.step_size}, 24'(speed_exp[i]));
        end

        pat = {12'hFFF, 6'b111001, 6'b111111};
        pressNext(2, pat);
        runFrames(4, pat);
        checkOutput("pre reset lvl1", {18'd0, vid.rgb}, {18'd0, 6'b010101});
        rst = 1'b1;
        applyStimulus(10'd5, 10'd10, pat, 1);
        checkOutput("mid fade rst rgb", {18'd0, vid.rgb}, 24'd0);
        checkOutput("mid fade rst sel", {22'd0, vid.pattern_sel}, 24'd0);
        checkOutput("mid fade rst step", {21'd0, vid.step_size}, 24'd1);
        rst = 1'b0;
        applyStimulus(10'd5, 10'd10, pat, 1);
        checkOutput("post rst level3", {18'd0, vid.rgb}, 24'h3F);
        runFrames(2, pat);
        checkOutput("post rst no fade", {18'd0, vid.rgb}, 24'h3F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
